pi1_wrbuf: RTL

Write-posting request buffer between one PerInt master and one master port of the PerInt interconnect. Writes are queued in a DEPTH-entry FIFO and acknowledged upstream immediately. Reads and read-writes are queued behind pending writes and stall the master until downstream data returns. This decouples CPU/DMA write bursts from slave latency and keeps strict request ordering.

---
 rtl/pi1_wrbuf_pkg.sv | 23 ++
 rtl/pi1_wrbuf_fifo.sv | 58 +++++
 rtl/pi1_wrbuf.sv | 111 +++++++++++
 3 files changed

// File: rtl/pi1_wrbuf_pkg.sv
// Shared PerInt definitions: op encodings, upstream FSM states and a
// constant-evaluable clog2 used for parameter-derived widths.
package pi1_wrbuf_pkg;

  localparam logic [1:0] PINOOP = 2'b00;
  localparam logic [1:0] PIWROP = 2'b01;
  localparam logic [1:0] PIRDOP = 2'b10;
  localparam logic [1:0] PIRWOP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RDWAIT = 2'd1,
    ST_RDRET  = 2'd2
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pi1_wrbuf_fifo.sv
// Synchronous FIFO with combinational head read; the head reads as zero when
// empty so downstream fields are clean without extra muxing.
module pi1_fifo
  import pi1_wrbuf_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pi1_wrbuf.sv
// Write-posting PerInt request buffer: writes are acked on entry, reads stall
// the master until the single in-flight read returns from downstream.
module pi1_wrbuf
  import pi1_wrbuf_pkg::*;
#(
  parameter int ARCHBITSZ = 32,
  parameter int DEPTH     = 4,
  localparam int ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ / 8),
  localparam int SELW      = ARCHBITSZ / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           m_op_i,
  input  logic [ADDRBITSZ-1:0] m_addr_i,
  input  logic [ARCHBITSZ-1:0] m_data_i,
  input  logic [SELW-1:0]      m_sel_i,
  output logic [ARCHBITSZ-1:0] m_data_o,
  output logic                 m_rdy_o,
  output logic [1:0]           s_op_o,
  output logic [ADDRBITSZ-1:0] s_addr_o,
  output logic [ARCHBITSZ-1:0] s_data_o,
  output logic [SELW-1:0]      s_sel_o,
  input  logic [ARCHBITSZ-1:0] s_data_i,
  input  logic                 s_rdy_i
);

  localparam int EW = 2 + ADDRBITSZ + ARCHBITSZ + SELW;
  localparam int CW = clog2(DEPTH) + 1;

  state_t                 r_state;
  logic                   r_rdpend;
  logic                   r_rddone;
  logic [ARCHBITSZ-1:0]   r_rddat;

  logic [EW-1:0]          w_wdat;
  logic [EW-1:0]          w_head;
  logic [CW-1:0]          w_count;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_accept;
  logic                   w_acc_rd;
  logic                   w_pop;
  logic                   w_pop_rd;
  logic                   w_capture;

  assign w_wdat = {m_op_i, m_addr_i, m_data_i, m_sel_i};

  pi1_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_accept),
    .i_data  (w_wdat),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign s_op_o   = (rst_i || w_empty) ? PINOOP : w_head[EW-1 -: 2];
  assign s_addr_o = w_head[EW-3 -: ADDRBITSZ];
  assign s_data_o = w_head[SELW +: ARCHBITSZ];
  assign s_sel_o  = w_head[SELW-1:0];

  assign m_rdy_o  = !rst_i && (((r_state == ST_IDLE) && !w_full) || (r_state == ST_RDRET));
  assign m_data_o = rst_i ? '0 : r_rddat;

  // RD and RW share bit 1 of the op encoding.
  assign w_accept  = m_rdy_o && (m_op_i != PINOOP) && !w_full;
  assign w_acc_rd  = w_accept && m_op_i[1];
  assign w_pop     = (s_op_o != PINOOP) && s_rdy_i;
  assign w_pop_rd  = w_pop && s_op_o[1];
  assign w_capture = r_rdpend && s_rdy_i && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_rdpend <= 1'b0;
      r_rddone <= 1'b0;
      r_rddat  <= '0;
    end else begin
      if (w_capture) r_rddat <= s_data_i;

      if (w_pop_rd)       r_rdpend <= 1'b1;
      else if (w_capture) r_rdpend <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_acc_rd) r_state <= ST_RDWAIT;
        end
        // Hold returned data here while full so RDRET never sees a full FIFO.
        ST_RDWAIT: begin
          if ((w_capture || r_rddone) && !w_full) begin
            r_state  <= ST_RDRET;
            r_rddone <= 1'b0;
          end else if (w_capture) begin
            r_rddone <= 1'b1;
          end
        end
        ST_RDRET: begin
          r_state <= w_acc_rd ? ST_RDWAIT : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
